// File: rtl/bclk_training_ctrl.sv
// bclk_training_ctrl: sweeps the BCLK input delay for two sampling-edge transitions,
// backs off to the eye centre, then observes the eye monitor and reports status.
module bclk_training_ctrl #(
   parameter int SETTLE_CYCLES    = 8,
   parameter int MAX_TAPS         = 128,
   parameter int MIN_GAP          = 4,
   parameter int EYE_CHECK_CYCLES = 64
) (
   input  logic       FAB_CLK,
   input  logic       ARST_N,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       fail,
   output logic [1:0] fail_code,
   output logic [7:0] edge0_tap,
   output logic [7:0] edge1_tap,
   output logic [7:0] final_tap,
   output logic       eye_early,
   output logic       eye_late,
   output logic       DELAY_LINE_LOAD,
   output logic       DELAY_LINE_MOVE,
   output logic       DELAY_LINE_DIRECTION,
   input  logic       DELAY_LINE_OUT_OF_RANGE,
   output logic       EYE_MONITOR_CLEAR_FLAGS,
   input  logic       EYE_MONITOR_EARLY,
   input  logic       EYE_MONITOR_LATE,
   input  logic [7:0] RX_DATA
);
   typedef enum logic [3:0] {
      IDLE, LOAD, SETTLE, SAMPLE, STEP, CENTER, CSETTLE, EYE_CLR, EYE_CHK, DONE, FAIL
   } state_t;
   state_t state, nstate;
   logic [15:0] cnt;
   logic [7:0] prev_sample, mid;
   logic [8:0] sum;
   logic [1:0] code_d;
   logic prev_valid, edge0_found, changed, smp, inc_mv, dec_mv;
   assign sum = {1'b0, edge0_tap} + {1'b0, edge1_tap};
   assign mid = 8'(sum >> 1);
   assign changed = prev_valid && (RX_DATA != prev_sample);
   assign smp = (state == SAMPLE) && (nstate != FAIL);
   assign inc_mv = (state == STEP) && (nstate == SETTLE);
   assign dec_mv = (state == CENTER) && (nstate == CSETTLE);
   always_comb begin
      nstate = state;
      code_d = fail_code;
      case (state)
         IDLE:    if (start) begin
                     nstate = LOAD;
                     code_d = 2'b00;
                  end
         LOAD:    nstate = SETTLE;
         SETTLE:  if (cnt == 16'(SETTLE_CYCLES - 1)) nstate = SAMPLE;
         SAMPLE:  nstate = (changed && edge0_found && (final_tap - edge0_tap) >= 8'(MIN_GAP)) ? CENTER : STEP;
         STEP:    if (final_tap == 8'(MAX_TAPS - 1)) begin
                     nstate = FAIL;
                     code_d = edge0_found ? 2'b10 : 2'b01;
                  end else nstate = SETTLE;
         // direction must already read 0 for a cycle before the first decrement
         CENTER:  nstate = (final_tap == mid) ? EYE_CLR : (!DELAY_LINE_DIRECTION ? CSETTLE : CENTER);
         CSETTLE: if (cnt == 16'(SETTLE_CYCLES - 1)) nstate = CENTER;
         EYE_CLR: nstate = EYE_CHK;
         EYE_CHK: if (cnt == 16'(EYE_CHECK_CYCLES - 1)) nstate = DONE;
         default: nstate = IDLE;
      endcase
      if (DELAY_LINE_OUT_OF_RANGE && !(state inside {IDLE, DONE, FAIL})) begin
         nstate = FAIL;
         code_d = 2'b11;
      end
   end
   always_ff @(posedge FAB_CLK or negedge ARST_N)
      if (!ARST_N) state <= IDLE;
      else state <= nstate;
   always_ff @(posedge FAB_CLK or negedge ARST_N) begin
      if (!ARST_N) begin
         cnt                     <= '0;
         busy                    <= 1'b0;
         done                    <= 1'b0;
         fail                    <= 1'b0;
         fail_code               <= '0;
         edge0_tap               <= '0;
         edge1_tap               <= '0;
         final_tap               <= '0;
         eye_early               <= 1'b0;
         eye_late                <= 1'b0;
         DELAY_LINE_LOAD         <= 1'b0;
         DELAY_LINE_MOVE         <= 1'b0;
         DELAY_LINE_DIRECTION    <= 1'b0;
         EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
         prev_sample             <= '0;
         prev_valid              <= 1'b0;
         edge0_found             <= 1'b0;
      end else begin
         cnt                     <= (nstate == state) ? cnt + 16'd1 : '0;
         busy                    <= !(nstate inside {IDLE, DONE, FAIL});
         done                    <= nstate == DONE;
         fail                    <= nstate == FAIL;
         fail_code               <= code_d;
         DELAY_LINE_LOAD         <= (state == LOAD) && (nstate == SETTLE);
         DELAY_LINE_MOVE         <= inc_mv || dec_mv;
         EYE_MONITOR_CLEAR_FLAGS <= (state == EYE_CLR) && (nstate == EYE_CHK);
         if (state == LOAD || inc_mv) DELAY_LINE_DIRECTION <= 1'b1;
         else if (state == CENTER) DELAY_LINE_DIRECTION <= 1'b0;
         if (state == LOAD) final_tap <= '0;
         else if (inc_mv) final_tap <= final_tap + 8'd1;
         else if (dec_mv) final_tap <= final_tap - 8'd1;
         if (state == LOAD) prev_valid <= 1'b0;
         else if (smp) prev_valid <= 1'b1;
         if (smp) prev_sample <= RX_DATA;
         if (state == IDLE && start) begin
            edge0_tap   <= '0;
            edge1_tap   <= '0;
            edge0_found <= 1'b0;
            eye_early   <= 1'b0;
            eye_late    <= 1'b0;
         end
         if (smp && changed && !edge0_found) begin
            edge0_tap   <= final_tap;
            edge0_found <= 1'b1;
         end
         if (smp && nstate == CENTER) edge1_tap <= final_tap;
         if (state == EYE_CHK && nstate != FAIL) begin
            eye_early <= eye_early | EYE_MONITOR_EARLY;
            eye_late  <= eye_late | EYE_MONITOR_LATE;
         end
      end
   end
endmodule

// File: tb/tb_bclk_training_ctrl.sv
// tb_bclk_training_ctrl: directed training runs against a lane model whose RX data flips at chosen taps.
module tb_bclk_training_ctrl;
   logic FAB_CLK = 0, ARST_N = 1, start = 0, oor = 0, early = 0, late = 0;
   logic busy, done, fail, ld, mv, dir, clr, eye_early, eye_late;
   logic [1:0] fail_code;
   logic [7:0] edge0_tap, edge1_tap, final_tap, rx;
   int tap = 0, f0 = 255, f1 = 255, f2 = 255;
   int n_ld = 0, n_inc = 0, n_dec = 0, n_clr = 0, n_ovl = 0, n_dirbad = 0;
   logic pdir = 0;
   int total = 0, bad = 0;
   int r_done, r_fail, d_ld, d_inc, d_dec, d_clr;

   bclk_training_ctrl dut (
      .FAB_CLK(FAB_CLK), .ARST_N(ARST_N), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_code(fail_code), .edge0_tap(edge0_tap), .edge1_tap(edge1_tap), .final_tap(final_tap),
      .eye_early(eye_early), .eye_late(eye_late), .DELAY_LINE_LOAD(ld), .DELAY_LINE_MOVE(mv),
      .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_OUT_OF_RANGE(oor), .EYE_MONITOR_CLEAR_FLAGS(clr),
      .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late), .RX_DATA(rx)
   );

   always #5 FAB_CLK = ~FAB_CLK;
   assign rx = ((tap >= f0) ^ (tap >= f1) ^ (tap >= f2)) ? 8'hAA : 8'h55;

   always @(posedge FAB_CLK) begin
      pdir <= dir;
      if (ld) tap <= 0;
      else if (mv) tap <= dir ? tap + 1 : tap - 1;
      n_ld  <= n_ld + int'(ld);
      n_inc <= n_inc + int'(mv && dir);
      n_dec <= n_dec + int'(mv && !dir);
      n_clr <= n_clr + int'(clr);
      if (int'(ld) + int'(mv) + int'(clr) > 1) n_ovl <= n_ovl + 1;
      if (mv && dir != pdir) n_dirbad <= n_dirbad + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic run(input int a, input int b, input int c, input bit do_late, input bit poke);
      int l0, i0, e0, c0;
      bit sent;
      f0 = a; f1 = b; f2 = c;
      l0 = n_ld; i0 = n_inc; e0 = n_dec; c0 = n_clr;
      sent = 0;
      @(negedge FAB_CLK) start = 1;
      @(negedge FAB_CLK) start = 0;
      chk("busy_rise", int'(busy), 1);
      chk("load_not_yet", int'(ld), 0);
      @(negedge FAB_CLK);
      chk("load_lat2", int'(ld), 1);
      for (int k = 0; k < 20000 && !(done || fail); k++) begin
         @(negedge FAB_CLK);
         late = 0;
         if (do_late && clr && !sent) begin
            late = 1;
            sent = 1;
         end
         start = (poke && k == 50) ? 1'b1 : 1'b0;
      end
      late = 0;
      start = 0;
      if (!(done || fail)) chk("timeout", 0, 1);
      r_done = int'(done); r_fail = int'(fail);
      d_ld = n_ld - l0; d_inc = n_inc - i0; d_dec = n_dec - e0; d_clr = n_clr - c0;
   endtask

   task automatic good_result(input string tag, input int e1, input int fin, input int dec);
      chk({tag, "_done"}, r_done, 1);
      chk({tag, "_fail"}, r_fail, 0);
      chk({tag, "_code"}, int'(fail_code), 0);
      chk({tag, "_edge0"}, int'(edge0_tap), 10);
      chk({tag, "_edge1"}, int'(edge1_tap), e1);
      chk({tag, "_final"}, int'(final_tap), fin);
      chk({tag, "_lane_tap"}, tap, fin);
      chk({tag, "_inc"}, d_inc, e1);
      chk({tag, "_dec"}, d_dec, dec);
      chk({tag, "_loads"}, d_ld, 1);
      chk({tag, "_clears"}, d_clr, 1);
      chk({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      #2 ARST_N = 0;
      repeat (3) @(negedge FAB_CLK);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_code", int'(fail_code), 0);
      chk("rst_final", int'(final_tap), 0);
      chk("rst_edge0", int'(edge0_tap), 0);
      chk("rst_ctl", {28'd0, ld, mv, dir, clr}, 0);
      chk("rst_eye", {30'd0, eye_early, eye_late}, 0);
      ARST_N = 1;
      repeat (3) @(negedge FAB_CLK);
      chk("idle_no_load", n_ld, 0);

      run(10, 30, 255, 0, 0);
      good_result("basic", 30, 20, 10);
      chk("basic_eye_late", int'(eye_late), 0);

      run(10, 12, 40, 0, 1);
      good_result("jitter", 40, 25, 15);

      run(255, 255, 255, 0, 0);
      chk("flat_fail", r_fail, 1);
      chk("flat_done", r_done, 0);
      chk("flat_code", int'(fail_code), 1);
      chk("flat_inc", d_inc, 127);
      chk("flat_dec", d_dec, 0);
      chk("flat_final", int'(final_tap), 127);
      chk("flat_busy", int'(busy), 0);

      f0 = 10; f1 = 30; f2 = 255;
      @(negedge FAB_CLK) start = 1;
      @(negedge FAB_CLK) start = 0;
      for (int k = 0; k < 5000 && tap != 20; k++) @(negedge FAB_CLK);
      chk("oor_reach20", tap, 20);
      oor = 1;
      @(posedge FAB_CLK);
      #1;
      chk("oor_fail", int'(fail), 1);
      chk("oor_code", int'(fail_code), 3);
      chk("oor_busy", int'(busy), 0);
      @(negedge FAB_CLK) oor = 0;
      chk("oor_code_held", int'(fail_code), 3);
      run(10, 30, 255, 0, 0);
      good_result("after_oor", 30, 20, 10);

      run(10, 30, 255, 1, 0);
      good_result("eye", 30, 20, 10);
      chk("eye_late", int'(eye_late), 1);
      chk("eye_early", int'(eye_early), 0);

      @(negedge FAB_CLK) start = 1;
      @(negedge FAB_CLK) start = 0;
      for (int k = 0; k < 5000 && tap != 15; k++) @(negedge FAB_CLK);
      chk("rst_reach15", tap, 15);
      ARST_N = 0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_final", int'(final_tap), 0);
      chk("mid_rst_ctl", {28'd0, ld, mv, dir, clr}, 0);
      chk("mid_rst_eye", int'(eye_late), 0);
      repeat (3) @(negedge FAB_CLK);
      ARST_N = 1;
      d_ld = n_ld;
      repeat (30) @(negedge FAB_CLK);
      chk("post_rst_no_load", n_ld - d_ld, 0);
      chk("post_rst_busy", int'(busy), 0);
      run(10, 30, 255, 0, 0);
      good_result("post_rst", 30, 20, 10);

      chk("pulse_overlap", n_ovl, 0);
      chk("dir_unstable", n_dirbad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bclk_training_ctrl.md
Name: bclk_training_ctrl

Overview:
Fabric-side controller for the DDR4 BCLK training input lane. It drives the lane's delay-line and eye-monitor controls and reads back the lane's deserialised data and eye flags. It sweeps the input delay to find two consecutive sampling-edge transitions, then backs the delay off to the eye centre. Finally it runs an eye-monitor check and reports the status to the training sequencer.

Parameters:
SETTLE_CYCLES, 8, FAB_CLK cycles to wait after any LOAD/MOVE before sampling RX_DATA (range 2..255)
MAX_TAPS, 128, sweep limit in delay taps (range 2..256)
MIN_GAP, 4, minimum taps between edge0 and edge1 (filters edge jitter)
EYE_CHECK_CYCLES, 64, cycles the eye monitor is observed after centring

Ports:
FAB_CLK  input  1  sole clock, same clock as the lane RX_CLK
ARST_N  input  1  asynchronous active-low reset
start  input  1  one-cycle request to train; ignored while busy=1
busy  output  1  training in progress
done  output  1  one-cycle pulse on success
fail  output  1  one-cycle pulse on failure
fail_code  output  2  00 none, 01 no edge0, 10 no edge1, 11 delay out of range; held until next start
edge0_tap  output  8  tap of first transition
edge1_tap  output  8  tap of second transition
final_tap  output  8  current delay-line tap count
eye_early  output  1  sticky EYE_MONITOR_EARLY seen during check
eye_late  output  1  sticky EYE_MONITOR_LATE seen during check
DELAY_LINE_LOAD  output  1  one-cycle pulse, delay line to base value
DELAY_LINE_MOVE  output  1  one-cycle pulse, one tap step
DELAY_LINE_DIRECTION  output  1  1 = increment, 0 = decrement; stable in and around MOVE cycle
DELAY_LINE_OUT_OF_RANGE  input  1  from lane
EYE_MONITOR_CLEAR_FLAGS  output  1  one-cycle pulse
EYE_MONITOR_EARLY  input  1  from lane
EYE_MONITOR_LATE  input  1  from lane
RX_DATA  input  8  deserialised BCLK samples from lane

Behaviour:
- Reset (async assert, sync deassert by ARST_N release on FAB_CLK): state IDLE; every output 0, DIRECTION 0; tap counters 0; sticky flags 0.
- States: IDLE, LOAD, SETTLE, SAMPLE, STEP, CENTER, CSETTLE, EYE_CLR, EYE_CHK, DONE, FAIL.
- IDLE: start=1 -> LOAD; busy goes 1 the next cycle; fail_code, edge taps and sticky flags are cleared.
- LOAD: DELAY_LINE_LOAD=1 for exactly one cycle; final_tap:=0; prev_valid:=0 -> SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE: RX_DATA is registered. If prev_valid=1 and sample != prev_sample:
  - edge0 not yet found: edge0_tap:=final_tap.
  - edge0 found and final_tap-edge0_tap >= MIN_GAP: edge1_tap:=final_tap -> CENTER.
  - In all cases prev_sample:=sample and prev_valid:=1.
  - Otherwise -> STEP.
- STEP:
  - final_tap == MAX_TAPS-1 -> FAIL, fail_code 01 if no edge0, else 10.
  - Otherwise DIRECTION=1, MOVE=1 for one cycle; final_tap+1 -> SETTLE.
- CENTER: mid = (edge0_tap+edge1_tap)>>1, using a 9-bit sum and truncating. Issue edge1_tap-mid decrement steps:
  - DIRECTION=0 is set one cycle before MOVE and held through it.
  - Each MOVE is followed by CSETTLE (SETTLE_CYCLES cycles); final_tap-1 per step.
  - When final_tap == mid -> EYE_CLR.
- EYE_CLR: EYE_MONITOR_CLEAR_FLAGS=1 for one cycle -> EYE_CHK.
- EYE_CHK: for EYE_CHECK_CYCLES cycles, OR EYE_MONITOR_EARLY/LATE into eye_early/eye_late -> DONE. Eye flags are informational only and never cause fail.
- DONE: done=1 for one cycle, busy:=0 -> IDLE. FAIL: fail=1 for one cycle, busy:=0 -> IDLE.
- DELAY_LINE_OUT_OF_RANGE=1 in any state other than IDLE/DONE/FAIL -> FAIL with fail_code 11. This takes priority over same-cycle edge detection.
- LOAD, MOVE and CLEAR_FLAGS are never asserted in the same cycle. At most one MOVE per SETTLE window.
- start while busy: ignored, no effect on the sequence.
- Reset mid-operation: all pulses drop immediately; no LOAD is issued until the next start.
- All outputs are registered. Latency from start to the first LOAD pulse is 2 cycles.

Test Plan:
- RX_DATA model flips 8'h55->8'hAA at tap 10 and back at tap 30; pulse start -> edge0_tap=10, edge1_tap=30, 10 decrement MOVEs, final_tap=20, done pulse, fail_code=00.
- RX_DATA flips at tap 10 and at tap 12 (jitter < MIN_GAP=4), then again at tap 40 -> edge1_tap=40, final_tap=25.
- RX_DATA constant 8'h55 -> 127 increment MOVEs, fail pulse, fail_code=01, busy=0; no CENTER MOVEs.
- DELAY_LINE_OUT_OF_RANGE raised at tap 20 -> fail next cycle, fail_code=11. Then start again with OOR low and a good model -> done.
- EYE_MONITOR_LATE pulsed once during EYE_CHK -> eye_late=1, eye_early=0, done still pulses. Check exactly one CLEAR_FLAGS pulse per run.
- ARST_N low mid-sweep at tap 15 -> all outputs 0 during reset; after release no LOAD until start; second start gives a full run with LOAD first.
